decoder_scan_n: RTL
===================

// Module: decoder_scan_n
// PURPOSE
//   Registered, parametrised N-to-2^N one-hot decoder with a built-in scan mode.
//   DECODE mode latches an N-bit code and drives the matching one-hot line.
//   SCAN mode walks the one-hot line through all 2^N positions, holding each for DWELL cycles.
//   Sits between control logic and multiplexed loads (display digit select, bank/row select).
// PARAMETERS
//   N      2  input code width; output width is 2**N (N >= 1)
//   DWELL  4  cycles each position is held in SCAN mode (DWELL >= 1)
// PORTS
//   CLK    in   1      clock, all state updates on rising edge
//   RST_N  in   1      asynchronous, active-low reset
//   EN     in   1      block enable; 0 forces IDLE
//   MODE   in   1      0 = DECODE, 1 = SCAN
//   LOAD   in   1      strobe: capture IN (DECODE) / jump to IN (SCAN)
//   IN     in   N      code to decode / scan jump target
//   OUT    out  2**N   registered one-hot select, all-zero when idle
//   IDX    out  N      binary index of the active OUT bit
//   VALID  out  1      1 when OUT holds a one-hot value (VALID == |OUT)
//   WRAP   out  1      one-cycle pulse when SCAN wraps from 2**N-1 to 0
// BEHAVIOUR
//   Reset (RST_N=0, asynchronous): state=IDLE, OUT=0, IDX=0, VALID=0, WRAP=0, dwell count=0.
//   All outputs are registered; every input takes effect at the next rising edge (latency 1).
//   OUT is always either all-zero or exactly one-hot; OUT[k]=1 implies IDX==k.
//   States: IDLE, DECODE, SCAN. Priority order per edge: EN=0 > MODE > LOAD.
//   EN=0 (any state): -> IDLE; OUT=0, VALID=0, dwell count=0; IDX holds its value.
//   IDLE, EN=1, MODE=0: LOAD=1 -> DECODE with OUT=1<<IN, IDX=IN; LOAD=0 -> stay IDLE.
//   IDLE, EN=1, MODE=1 -> SCAN with IDX=0, OUT=1, count=0 (LOAD=1 on the same edge: IDX=IN instead).
//   DECODE, EN=1, MODE=0: LOAD=1 -> OUT/IDX reload from IN; LOAD=0 -> hold OUT/IDX.
//   DECODE, EN=1, MODE=1 -> SCAN entry exactly as from IDLE (restart at 0, or at IN if LOAD=1).
//   SCAN, EN=1, MODE=1, LOAD=0: count increments each cycle. When count==DWELL-1: count->0 and
//     IDX -> IDX+1 mod 2**N, OUT rotates left by one (bit 2**N-1 wraps to bit 0).
//   SCAN, LOAD=1: IDX=IN, OUT=1<<IN, count=0 (resync; no WRAP pulse).
//   SCAN, EN=1, MODE=0 -> DECODE: OUT/IDX hold the current scan position; LOAD=1 on the same
//     edge loads IN instead.
//   WRAP=1 for exactly one cycle, coincident with the first cycle of IDX==0 after a
//     2**N-1 -> 0 advance. WRAP is 0 on SCAN entry, on LOAD jumps and in all other states.
//   DWELL=1: advance every cycle; the dwell counter may be optimised away. Counter width is
//     max(1, clog2(DWELL)).
//   N=1: OUT is 2 bits; SCAN alternates 01/10 and WRAP fires on every return to bit 0.
//   Reset asserted mid-scan clears immediately (asynchronously); after release the block
//     resumes from IDLE.
// TESTING  (N=2, DWELL=3 unless stated)
//   Reset, then EN=1,MODE=0, LOAD pulses with IN=0,1,2,3 -> each next cycle OUT=0001,0010,0100,1000,
//     IDX=IN, VALID=1.
//   EN=1,MODE=1 from IDLE -> OUT=0001 for 3 cycles, then 0010,0100,1000 (3 cycles each), then 0001
//     with WRAP=1 for that single cycle; repeats every 12 cycles.
//   Mid-SCAN at IDX=1, LOAD=1 with IN=3 -> next cycle OUT=1000, IDX=3, held for 3 full cycles,
//     then OUT=0001 with WRAP=1.
//   Mid-SCAN at IDX=2, MODE->0 with LOAD=0 -> OUT=0100 held indefinitely; EN->0 -> next cycle OUT=0000,
//     VALID=0.
//   Assert RST_N=0 between edges during SCAN -> OUT=0, IDX=0, WRAP=0 with no clock edge; release,
//     MODE=1 -> scan restarts at 0001.
//   Rerun with N=3, DWELL=1 -> OUT walks 1 bit per cycle across 8 lines; WRAP every 8 cycles;
//     one-hot/IDX consistency asserted every cycle.

Source files
------------

// File: rtl/decoder_scan_n.sv
// ----------------------------------------------------------------------------
// decoder_scan_n
//   Registered N-to-2^N one-hot decoder with a built-in scan mode.
//   DECODE mode captures an N-bit code and drives the matching one-hot line.
//   SCAN mode walks the one-hot line through all 2^N positions, holding each
//   position for DWELL cycles, with a one-cycle WRAP pulse on return to 0.
//
// Parameters
//   N      code width; output width is 2**N (N >= 1)
//   DWELL  cycles each position is held in SCAN mode (DWELL >= 1)
//
// Ports
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   en     in   1      block enable; 0 forces IDLE
//   mode   in   1      0 = DECODE, 1 = SCAN
//   load   in   1      capture in (DECODE) / jump to in (SCAN)
//   in     in   N      code to decode / scan jump target
//   out    out  2**N   registered one-hot select, all-zero when idle
//   idx    out  N      binary index of the active out bit
//   valid  out  1      out holds a one-hot value
//   wrap   out  1      one-cycle pulse when SCAN wraps from 2**N-1 to 0
// ----------------------------------------------------------------------------
module decoder_scan_n #(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic              load,
    input  logic [N-1:0]      in,
    output logic [2**N-1:0]   out,
    output logic [N-1:0]      idx,
    output logic              valid,
    output logic              wrap
);

    localparam int W  = 2**N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    out_n;
    logic [N-1:0]    idx_n;
    logic            valid_n;
    logic            wrap_n;
    logic [CW-1:0]   cnt, cnt_n;

    function automatic logic [W-1:0] onehot(input logic [N-1:0] code);
        onehot = {{(W-1){1'b0}}, 1'b1} << code;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            out   <= '0;
            idx   <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            out   <= out_n;
            idx   <= idx_n;
            valid <= valid_n;
            wrap  <= wrap_n;
            cnt   <= cnt_n;
        end
    end

    // Priority per edge: en=0, then mode, then load.
    always_comb begin
        state_n = state;
        out_n   = out;
        idx_n   = idx;
        cnt_n   = cnt;
        wrap_n  = 1'b0;

        if (!en) begin
            // idx deliberately keeps its last value while idle.
            state_n = IDLE;
            out_n   = '0;
            cnt_n   = '0;
        end else if (mode) begin
            if (state != SCAN || load) begin
                // Scan entry and in-scan jumps both restart the dwell period
                // and never raise wrap.
                state_n = SCAN;
                idx_n   = load ? in : '0;
                out_n   = onehot(idx_n);
                cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
                cnt_n  = '0;
                idx_n  = idx + 1'b1;
                out_n  = {out[W-2:0], out[W-1]};
                wrap_n = &idx;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end else begin
            cnt_n = '0;
            if (load) begin
                state_n = DECODE;
                idx_n   = in;
                out_n   = onehot(in);
            end else if (state != IDLE) begin
                // Leaving SCAN freezes the current scan position.
                state_n = DECODE;
            end
        end

        valid_n = |out_n;
    end

endmodule
